// File: rtl/pwm_led_bank.sv
// N-channel LED PWM driver with double-buffered duty registers and a tick prescaler.
// Define PWM_LED_FADE_EN to slew active duties one step per period toward their targets.
module pwm_led_bank #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter bit INVERT   = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [2:0]                   wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_start,
    output logic [CHANNELS*WIDTH-1:0]    duty_rd
);

    localparam int              PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'((2 ** WIDTH) - 2);

    logic [PS_W-1:0]     ps_cnt;
    logic                tick;
    logic                boundary;
    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    shadow      [CHANNELS];
    logic [WIDTH-1:0]    active      [CHANNELS];
    logic [WIDTH-1:0]    target      [CHANNELS];
    logic [WIDTH-1:0]    next_active [CHANNELS];
    logic [CHANNELS-1:0] wr_hit;

    assign tick     = (ps_cnt == PS_LAST);
    assign boundary = tick && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // The counter stops one short of all-ones so a full-scale duty stays on forever.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (boundary) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A write landing on the boundary is forwarded so it is not lost for a period.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            wr_hit[ch] = wr_en && (wr_addr == 3'(ch));
            target[ch] = wr_hit[ch] ? wr_data : shadow[ch];
`ifdef PWM_LED_FADE_EN
            if (active[ch] < target[ch]) begin
                next_active[ch] = active[ch] + 1'b1;
            end else if (active[ch] > target[ch]) begin
                next_active[ch] = active[ch] - 1'b1;
            end else begin
                next_active[ch] = active[ch];
            end
`else
            next_active[ch] = target[ch];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                shadow[ch] <= '0;
                active[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (wr_hit[ch]) begin
                    shadow[ch] <= wr_data;
                end
                if (boundary) begin
                    active[ch] <= next_active[ch];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out      <= {CHANNELS{INVERT}};
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                pwm_out[ch] <= (cnt < active[ch]) ^ INVERT;
            end
        end
    end

    always_comb begin
        duty_rd = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            duty_rd[ch*WIDTH +: WIDTH] = active[ch];
        end
    end

endmodule

// File: tb/tb_pwm_led_bank.sv
// Self-checking bench for pwm_led_bank: scoreboarded cycle expectations for a
// PRESCALE=1 instance plus a PRESCALE=4 instance checked for period length and duty.
module tb_pwm_led_bank;

    localparam int CH   = 3;
    localparam int LAST = 14;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [3:0]  wr_data;
    logic [2:0]  pwm_out;
    logic        period_start;
    logic [11:0] duty_rd;

    logic        wr_en4;
    logic [2:0]  wr_addr4;
    logic [3:0]  wr_data4;
    logic [2:0]  pwm_out4;
    logic        ps4;
    logic [11:0] duty_rd4;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0]  pwm;
        logic        ps;
        logic [11:0] duty;
    } exp_t;

    typedef struct packed {
        logic [2:0] pwm;
        logic       ps;
    } exp4_t;

    exp_t  exp_q[$];
    exp4_t exp4_q[$];

    int m_cnt;
    int m_shadow [CH];
    int m_active [CH];

    always #5 clk = ~clk;

    pwm_led_bank #(.CHANNELS(3), .WIDTH(4), .PRESCALE(1), .INVERT(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pwm_out(pwm_out), .period_start(period_start), .duty_rd(duty_rd)
    );

    pwm_led_bank #(.CHANNELS(3), .WIDTH(4), .PRESCALE(4), .INVERT(1'b1)) dut4 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .pwm_out(pwm_out4), .period_start(ps4), .duty_rd(duty_rd4)
    );

    function automatic void model_reset();
        m_cnt = 0;
        for (int ch = 0; ch < CH; ch++) begin
            m_shadow[ch] = 0;
            m_active[ch] = 0;
        end
    endfunction

    // Predict what the next clock edge produces from the inputs now on the bus, then take that edge.
    task automatic drive_cycle();
        exp_t e;
        bit   bnd;
        int   tgt;
        bnd   = (m_cnt == LAST);
        e.ps  = bnd;
        for (int ch = 0; ch < CH; ch++) begin
            e.pwm[ch] = (m_cnt < m_active[ch]) ? 1'b0 : 1'b1;
            tgt = (wr_en && (int'(wr_addr) == ch)) ? int'(wr_data) : m_shadow[ch];
            m_shadow[ch] = tgt;
            if (bnd) begin
`ifdef PWM_LED_FADE_EN
                if (m_active[ch] < tgt) m_active[ch]++;
                else if (m_active[ch] > tgt) m_active[ch]--;
`else
                m_active[ch] = tgt;
`endif
            end
            e.duty[ch*4 +: 4] = 4'(m_active[ch]);
        end
        m_cnt = bnd ? 0 : m_cnt + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic en, input logic [2:0] addr, input logic [3:0] data);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n = 1'b0;
        set_write(1'b0, 3'd0, 4'd0);
        wr_en4 = 1'b0; wr_addr4 = 3'd0; wr_data4 = 4'd0;
        model_reset();
        #12;
        n_checks++;
        if ({pwm_out, period_start, duty_rd} !== {3'b111, 1'b0, 12'h000}) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got pwm=%b ps=%b duty=%h, expected pwm=111 ps=0 duty=000",
                     pwm_out, period_start, duty_rd);
        end
        n_checks++;
        if ({pwm_out4, ps4, duty_rd4} !== {3'b111, 1'b0, 12'h000}) begin
            n_fail++;
            $display("[TB] FAIL reset_state_ps4: got pwm=%b ps=%b duty=%h, expected pwm=111 ps=0 duty=000",
                     pwm_out4, ps4, duty_rd4);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({pwm_out, period_start, duty_rd} !== e) begin
                n_fail++;
                $display("[TB] FAIL idle cycle %0d: got pwm=%b ps=%b duty=%h, expected pwm=%b ps=%b duty=%h",
                         i, pwm_out, period_start, duty_rd, e.pwm, e.ps, e.duty);
            end
        end
    endtask

    task automatic test_mid_write();
        exp_t e;
        int   lows = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) set_write(1'b1, 3'd0, 4'd5);
            else        set_write(1'b0, 3'd0, 4'd0);
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({pwm_out, period_start, duty_rd} !== e) begin
                n_fail++;
                $display("[TB] FAIL mid_write cycle %0d: got pwm=%b ps=%b duty=%h, expected pwm=%b ps=%b duty=%h",
                         i, pwm_out, period_start, duty_rd, e.pwm, e.ps, e.duty);
            end
            if (i > 15 && pwm_out[0] == 1'b0) lows++;
        end
`ifndef PWM_LED_FADE_EN
        n_checks++;
        if (lows != 5) begin
            n_fail++;
            $display("[TB] FAIL mid_write_on_time: got %0d on cycles, expected 5", lows);
        end
`endif
    endtask

    task automatic test_full_and_zero();
        exp_t e;
        for (int i = 1; i <= 30; i++) begin
            case (i)
                2:       set_write(1'b1, 3'd1, 4'd15);
                3:       set_write(1'b1, 3'd2, 4'd0);
                default: set_write(1'b0, 3'd0, 4'd0);
            endcase
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({pwm_out, period_start, duty_rd} !== e) begin
                n_fail++;
                $display("[TB] FAIL full_zero cycle %0d: got pwm=%b ps=%b duty=%h, expected pwm=%b ps=%b duty=%h",
                         i, pwm_out, period_start, duty_rd, e.pwm, e.ps, e.duty);
            end
`ifndef PWM_LED_FADE_EN
            if (i == 15) begin
                n_checks++;
                if (duty_rd !== 12'h0F5) begin
                    n_fail++;
                    $display("[TB] FAIL full_zero_duty_rd: got %h, expected 0f5", duty_rd);
                end
            end
            if (i > 15) begin
                n_checks++;
                if (pwm_out[2:1] !== 2'b10) begin
                    n_fail++;
                    $display("[TB] FAIL full_zero_levels cycle %0d: got %b, expected 10", i, pwm_out[2:1]);
                end
            end
`endif
        end
    endtask

    task automatic test_boundary_write();
        exp_t e;
        for (int i = 1; i <= 30; i++) begin
            case (i)
                5:       set_write(1'b1, 3'd2, 4'd3);
                6:       set_write(1'b1, 3'd3, 4'd9);
                8:       set_write(1'b1, 3'd0, 4'd2);
                10:      set_write(1'b1, 3'd0, 4'd5);
                15:      set_write(1'b1, 3'd2, 4'd7);
                default: set_write(1'b0, 3'd0, 4'd0);
            endcase
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({pwm_out, period_start, duty_rd} !== e) begin
                n_fail++;
                $display("[TB] FAIL boundary_write cycle %0d: got pwm=%b ps=%b duty=%h, expected pwm=%b ps=%b duty=%h",
                         i, pwm_out, period_start, duty_rd, e.pwm, e.ps, e.duty);
            end
`ifndef PWM_LED_FADE_EN
            if (i == 15) begin
                n_checks++;
                if (duty_rd !== 12'h7F5) begin
                    n_fail++;
                    $display("[TB] FAIL boundary_write_duty_rd: got %h, expected 7f5", duty_rd);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        set_write(1'b0, 3'd0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({pwm_out, period_start, duty_rd} !== e) begin
                n_fail++;
                $display("[TB] FAIL pre_reset cycle %0d: got pwm=%b ps=%b duty=%h, expected pwm=%b ps=%b duty=%h",
                         i, pwm_out, period_start, duty_rd, e.pwm, e.ps, e.duty);
            end
        end
        n_checks++;
        if (pwm_out[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_ch0_on: got %b, expected 0", pwm_out[0]);
        end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({pwm_out, period_start, duty_rd} !== {3'b111, 1'b0, 12'h000}) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got pwm=%b ps=%b duty=%h, expected pwm=111 ps=0 duty=000",
                     pwm_out, period_start, duty_rd);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({pwm_out, period_start, duty_rd} !== {3'b111, 1'b0, 12'h000}) begin
            n_fail++;
            $display("[TB] FAIL reset_held: got pwm=%b ps=%b duty=%h, expected pwm=111 ps=0 duty=000",
                     pwm_out, period_start, duty_rd);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++;
            if ({pwm_out, period_start, duty_rd} !== e) begin
                n_fail++;
                $display("[TB] FAIL post_reset cycle %0d: got pwm=%b ps=%b duty=%h, expected pwm=%b ps=%b duty=%h",
                         i, pwm_out, period_start, duty_rd, e.pwm, e.ps, e.duty);
            end
        end
    endtask

    task automatic test_duty_update();
        exp_t e;
        int   reads [6];
`ifdef PWM_LED_FADE_EN
        reads = '{1, 2, 3, 4, 3, 2};
`else
        reads = '{4, 4, 4, 4, 2, 2};
`endif
        for (int p = 0; p < 6; p++) begin
            for (int i = 1; i <= 15; i++) begin
                if (i == 3 && p == 0)      set_write(1'b1, 3'd0, 4'd4);
                else if (i == 3 && p == 4) set_write(1'b1, 3'd0, 4'd2);
                else                       set_write(1'b0, 3'd0, 4'd0);
                drive_cycle();
                e = exp_q.pop_front();
                n_checks++;
                if ({pwm_out, period_start, duty_rd} !== e) begin
                    n_fail++;
                    $display("[TB] FAIL duty_update p%0d cycle %0d: got pwm=%b ps=%b duty=%h, expected pwm=%b ps=%b duty=%h",
                             p, i, pwm_out, period_start, duty_rd, e.pwm, e.ps, e.duty);
                end
            end
            n_checks++;
            if (int'(duty_rd[3:0]) != reads[p]) begin
                n_fail++;
                $display("[TB] FAIL duty_update_read p%0d: got %0d, expected %0d", p, duty_rd[3:0], reads[p]);
            end
        end
    endtask

    task automatic test_prescale();
        exp4_t e;
        int    cyc;
        bit    found;
        int    exp_duty;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (ps4) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL prescale_first_start: got no period_start in 200 cycles, expected one");
        end
        cyc   = 0;
        found = 1'b0;
        while (cyc < 100 && !found) begin
            wr_en4   = (cyc == 0);
            wr_addr4 = 3'd0;
            wr_data4 = 4'd3;
            @(posedge clk);
            #1;
            cyc++;
            if (ps4) found = 1'b1;
        end
        wr_en4 = 1'b0;
        n_checks++;
        if (!found || cyc != 60) begin
            n_fail++;
            $display("[TB] FAIL prescale_period: got %0d cycles (found=%0d), expected 60", cyc, found);
        end
`ifdef PWM_LED_FADE_EN
        exp_duty = 1;
`else
        exp_duty = 3;
`endif
        n_checks++;
        if (int'(duty_rd4[3:0]) != exp_duty) begin
            n_fail++;
            $display("[TB] FAIL prescale_duty_rd: got %0d, expected %0d", duty_rd4[3:0], exp_duty);
        end
        for (int k = 1; k <= 60; k++) begin
            e.pwm = {2'b11, (k <= 4 * exp_duty) ? 1'b0 : 1'b1};
            e.ps  = (k == 60);
            exp4_q.push_back(e);
        end
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            e = exp4_q.pop_front();
            n_checks++;
            if ({pwm_out4, ps4} !== e) begin
                n_fail++;
                $display("[TB] FAIL prescale cycle %0d: got pwm=%b ps=%b, expected pwm=%b ps=%b",
                         k, pwm_out4, ps4, e.pwm, e.ps);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mid_write();
        test_full_and_zero();
        test_boundary_write();
        test_reset_mid();
        test_duty_update();
        test_prescale();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
